// File: rtl/operand_sequencer.sv
// operand_sequencer
//   Multi-cycle operand-fetch / writeback controller sitting in front of
//   register_file. One instruction is in flight at a time:
//     IDLE -> READ -> CAPTURE -> ISSUE -> WAIT_RES -> (WRITE) -> IDLE
//   Every output is decoded from registered state or latches; there is no
//   combinational path from any input to any output.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   instr_valid/instr_ready  decoded-instruction handshake (ready only in IDLE)
//   rd, rs1, rs2, wb_en      decoded instruction fields
//   rf_r_en1/2, rf_w_en      register_file port enables
//   rf_reg1, rf_reg2         register_file addresses (reg1 shared read/write)
//   rf_w_data                writeback data
//   rf_r_data1/2             register_file read data (1-cycle latency)
//   op_valid/op_ready        operand handshake to the ALU, op_a/op_b operands
//   res_valid/res_ready      result handshake from the ALU, res_data result
//   retired                  completed-instruction count, wraps
module operand_sequencer #(
  parameter int unsigned REG_COUNT = 8,
  parameter int unsigned ADDR_SIZE = $clog2(REG_COUNT),
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned RETIRE_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [ADDR_SIZE-1:0] rd,
  input  logic [ADDR_SIZE-1:0] rs1,
  input  logic [ADDR_SIZE-1:0] rs2,
  input  logic                 wb_en,
  output logic                 rf_r_en1,
  output logic                 rf_r_en2,
  output logic                 rf_w_en,
  output logic [ADDR_SIZE-1:0] rf_reg1,
  output logic [ADDR_SIZE-1:0] rf_reg2,
  output logic [WORD_SIZE-1:0] rf_w_data,
  input  logic [WORD_SIZE-1:0] rf_r_data1,
  input  logic [WORD_SIZE-1:0] rf_r_data2,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [WORD_SIZE-1:0] op_a,
  output logic [WORD_SIZE-1:0] op_b,
  input  logic                 res_valid,
  input  logic [WORD_SIZE-1:0] res_data,
  output logic                 res_ready,
  output logic [RETIRE_W-1:0]  retired
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRead    = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StIssue   = 3'd3;
  localparam logic [2:0] StWaitRes = 3'd4;
  localparam logic [2:0] StWrite   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] rd_q, rd_d;
  logic [ADDR_SIZE-1:0] rs2_q, rs2_d;
  logic                 wb_en_q, wb_en_d;
  // rf_reg1_q doubles as the latched rs1: loaded with rs1 on accept and
  // with rd on the way into WRITE, otherwise it holds its last value.
  logic [ADDR_SIZE-1:0] rf_reg1_q, rf_reg1_d;
  logic [ADDR_SIZE-1:0] rf_reg2_q, rf_reg2_d;
  logic [WORD_SIZE-1:0] op_a_q, op_a_d;
  logic [WORD_SIZE-1:0] op_b_q, op_b_d;
  logic [WORD_SIZE-1:0] res_q, res_d;
  logic [RETIRE_W-1:0]  retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    rs2_d     = rs2_q;
    wb_en_d   = wb_en_q;
    rf_reg1_d = rf_reg1_q;
    rf_reg2_d = rf_reg2_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    retired_d = retired_q;
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          rd_d      = rd;
          rs2_d     = rs2;
          wb_en_d   = wb_en;
          rf_reg1_d = rs1;
          rf_reg2_d = rs2;
          state_d   = StRead;
        end
      end
      StRead: begin
        state_d = StCapture;
      end
      StCapture: begin
        op_a_d  = rf_r_data1;
        // register_file only zeroes r0 on port 1, so port 2 is masked here.
        op_b_d  = (rs2_q == '0) ? '0 : rf_r_data2;
        state_d = StIssue;
      end
      StIssue: begin
        if (op_ready) begin
          state_d = StWaitRes;
        end
      end
      StWaitRes: begin
        if (res_valid) begin
          res_d = res_data;
          if (wb_en_q && (rd_q != '0)) begin
            rf_reg1_d = rd_q;
            state_d   = StWrite;
          end else begin
            retired_d = retired_q + RETIRE_W'(1);
            state_d   = StIdle;
          end
        end
      end
      StWrite: begin
        retired_d = retired_q + RETIRE_W'(1);
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rd_q      <= '0;
      rs2_q     <= '0;
      wb_en_q   <= 1'b0;
      rf_reg1_q <= '0;
      rf_reg2_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      rs2_q     <= rs2_d;
      wb_en_q   <= wb_en_d;
      rf_reg1_q <= rf_reg1_d;
      rf_reg2_q <= rf_reg2_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      res_q     <= res_d;
      retired_q <= retired_d;
    end
  end

  // Port-1 read must stay low in WRITE because register_file gives the read
  // priority over the write on that port; decoding from state guarantees it.
  assign instr_ready = (state_q == StIdle);
  assign rf_r_en1    = (state_q == StRead);
  assign rf_r_en2    = (state_q == StRead);
  assign rf_w_en     = (state_q == StWrite);
  assign rf_reg1     = rf_reg1_q;
  assign rf_reg2     = rf_reg2_q;
  assign rf_w_data   = res_q;
  assign op_valid    = (state_q == StIssue);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign res_ready   = (state_q == StWaitRes);
  assign retired     = retired_q;

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;
  localparam int AW = 3;
  localparam int WW = 16;
  localparam int RW = 6;  // narrow counter so the wrap is reachable quickly
  localparam int RMOD = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, instr_valid, instr_ready, wb_en;
  logic [AW-1:0] rd, rs1, rs2, rf_reg1, rf_reg2;
  logic rf_r_en1, rf_r_en2, rf_w_en;
  logic [WW-1:0] rf_w_data, rf_r_data1, rf_r_data2;
  logic op_valid, op_ready, res_valid, res_ready;
  logic [WW-1:0] op_a, op_b, res_data;
  logic [RW-1:0] retired;

  operand_sequencer #(.REG_COUNT(8), .WORD_SIZE(WW), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rd(rd), .rs1(rs1), .rs2(rs2), .wb_en(wb_en),
    .rf_r_en1(rf_r_en1), .rf_r_en2(rf_r_en2), .rf_w_en(rf_w_en),
    .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_w_data(rf_w_data),
    .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .retired(retired)
  );

  // Register-file model: 1-cycle reads, port 1 zeroes r0, port 2 does not,
  // port-1 read wins over write. pre_* is a bench-only preload path.
  logic [WW-1:0] mem [8];
  logic pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [WW-1:0] pre_data = '0;
  int wr_count = 0, wr_r0 = 0, acc_count = 0, rd_pulses = 0, res_hs = 0;

  always @(posedge clk) begin
    if (rf_r_en1) rf_r_data1 <= (rf_reg1 == 0) ? '0 : mem[rf_reg1];
    if (rf_r_en2) rf_r_data2 <= mem[rf_reg2];
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (rf_w_en && !rf_r_en1 && rf_reg1 != 0) mem[rf_reg1] <= rf_w_data;
    if (rf_w_en) wr_count <= wr_count + 1;
    if (rf_w_en && rf_reg1 == 0) wr_r0 <= wr_r0 + 1;
    if (instr_valid && instr_ready && !reset) acc_count <= acc_count + 1;
    if (rf_r_en1) rd_pulses <= rd_pulses + 1;
    if (res_valid && res_ready && !reset) res_hs <= res_hs + 1;
  end

  // Transaction-level reference: architectural register values and retire count.
  logic [WW-1:0] ref_regs [8];
  int exp_ret = 0;
  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout %s", name);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WW-1:0] v);
    pre_en = 1'b1; pre_addr = a; pre_data = v;
    @(negedge clk);
    pre_en = 1'b0;
    ref_regs[a] = v;
  endtask

  function automatic logic [WW-1:0] ref_read(input logic [AW-1:0] a);
    return (a == 0) ? '0 : ref_regs[a];
  endfunction

  // Accept an instruction and run until op_valid; lat counts cycles from accept.
  task automatic start_instr(input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input logic [AW-1:0] d, input logic w, output int lat);
    int n = 0;
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    if (!instr_ready) timeout("instr_ready_pre");
    instr_valid = 1'b1; rs1 = a; rs2 = b; rd = d; wb_en = w;
    @(negedge clk);
    instr_valid = 1'b0; rs1 = ~a; rs2 = ~b; rd = ~d; wb_en = ~w;  // must be latched
    lat = 1;
    while (!op_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!op_valid) timeout("op_valid");
  endtask

  task automatic finish_instr(input logic [AW-1:0] d, input logic w, input logic [WW-1:0] r,
                              input int stall, input int rdly, output bit stable);
    logic [WW-1:0] ha, hb;
    int n = 0;
    ha = op_a; hb = op_b; stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      res_valid = 1'b1; res_data = 16'hDEAD;  // must be ignored in ISSUE
      @(negedge clk);
      if (!op_valid || op_a !== ha || op_b !== hb) stable = 1'b0;
    end
    res_valid = 1'b0; op_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < rdly; i++) @(negedge clk);  // op_ready stays high, ignored
    op_ready = 1'b0; res_valid = 1'b1; res_data = r;
    @(negedge clk);
    res_valid = 1'b0;
    while (!instr_ready && n < 5) begin @(negedge clk); n++; end
    if (!instr_ready) timeout("instr_ready_post");
    if (w && d != 0) ref_regs[d] = r;
    exp_ret++;
  endtask

  typedef struct {
    logic [AW-1:0] rs1, rs2, rd;
    logic wb;
    logic [WW-1:0] res;
    int stall;
    logic [WW-1:0] ea, eb;
    int ewr;
  } vec_t;
  vec_t tbl [5];

  initial begin
    int lat, w0, r0c, a0, p0, h0, cyc;
    bit stable;
    logic [AW-1:0] a, b, d;
    logic w;
    logic [WW-1:0] r;

    tbl[0] = '{3'd3, 3'd5, 3'd2, 1'b1, 16'h1333, 0,  16'h1234, 16'h00FF, 1};
    tbl[1] = '{3'd3, 3'd0, 3'd4, 1'b1, 16'h0001, 0,  16'h1234, 16'h0000, 1};
    tbl[2] = '{3'd5, 3'd3, 3'd0, 1'b1, 16'hBEEF, 0,  16'h00FF, 16'h1234, 0};
    tbl[3] = '{3'd2, 3'd5, 3'd6, 1'b1, 16'h5555, 10, 16'h1333, 16'h00FF, 1};
    tbl[4] = '{3'd0, 3'd2, 3'd7, 1'b0, 16'h7777, 2,  16'h0000, 16'h1333, 0};

    reset = 1'b1; instr_valid = 1'b0; rd = '0; rs1 = '0; rs2 = '0; wb_en = 1'b0;
    op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    repeat (3) @(negedge clk);
    check("rst_instr_ready", 32'(instr_ready), 1);
    check("rst_enables", {29'd0, rf_r_en1, rf_r_en2, rf_w_en}, 0);
    check("rst_hs", {30'd0, op_valid, res_ready}, 0);
    check("rst_ops", {op_a, op_b}, 0);
    check("rst_retired", 32'(retired), 0);
    reset = 1'b0;

    preload(3'd0, 16'hDEAD);  // garbage in the r0 cell, visible on port 2 only
    preload(3'd1, 16'h1111); preload(3'd2, 16'h2222); preload(3'd3, 16'h1234);
    preload(3'd4, 16'h4444); preload(3'd5, 16'h00FF); preload(3'd6, 16'h6666);
    preload(3'd7, 16'h7777);

    for (int i = 0; i < 5; i++) begin
      w0 = wr_count; r0c = wr_r0;
      start_instr(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wb, lat);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 3);
      check($sformatf("tbl%0d_op_a", i), 32'(op_a), 32'(tbl[i].ea));
      check($sformatf("tbl%0d_op_b", i), 32'(op_b), 32'(tbl[i].eb));
      finish_instr(tbl[i].rd, tbl[i].wb, tbl[i].res, tbl[i].stall, 1, stable);
      check($sformatf("tbl%0d_stable", i), 32'(stable), 1);
      check($sformatf("tbl%0d_writes", i), 32'(wr_count - w0), 32'(tbl[i].ewr));
      check($sformatf("tbl%0d_r0_writes", i), 32'(wr_r0 - r0c), 0);
      check($sformatf("tbl%0d_retired", i), 32'(retired), i + 1);
      if (tbl[i].ewr != 0)
        check($sformatf("tbl%0d_rd_value", i), 32'(mem[tbl[i].rd]), 32'(tbl[i].res));
    end

    // Reset while a writeback result is being accepted: nothing may be written.
    start_instr(3'd1, 3'd1, 3'd5, 1'b1, lat);
    op_ready = 1'b1; @(negedge clk); op_ready = 1'b0;
    check("abort_res_ready", 32'(res_ready), 1);
    w0 = wr_count;
    res_valid = 1'b1; res_data = 16'hABCD; reset = 1'b1;
    @(negedge clk);
    res_valid = 1'b0; reset = 1'b0;
    check("abort_instr_ready", 32'(instr_ready), 1);
    check("abort_retired", 32'(retired), 0);
    check("abort_ops", {op_a, op_b}, 0);
    @(negedge clk);
    check("abort_no_write", 32'(wr_count - w0), 0);
    check("abort_r5", 32'(mem[5]), 32'(ref_regs[5]));
    exp_ret = 0;

    // Randomized instructions against the reference model.
    for (int i = 0; i < 30; i++) begin
      a = AW'($urandom_range(7)); b = AW'($urandom_range(7)); d = AW'($urandom_range(7));
      w = 1'($urandom_range(1)); r = WW'($urandom);
      w0 = wr_count;
      start_instr(a, b, d, w, lat);
      check("rand_latency", 32'(lat), 3);
      check("rand_op_a", 32'(op_a), 32'(ref_read(a)));
      check("rand_op_b", 32'(op_b), 32'(ref_read(b)));
      finish_instr(d, w, r, $urandom_range(3), $urandom_range(2), stable);
      check("rand_stable", 32'(stable), 1);
      check("rand_writes", 32'(wr_count - w0), (w && d != 0) ? 1 : 0);
      check("rand_retired", 32'(retired), exp_ret % RMOD);
    end
    for (int k = 1; k < 8; k++) check($sformatf("rand_reg%0d", k), 32'(mem[k]), 32'(ref_regs[k]));

    // Back-to-back with every handshake input held high; retired must wrap.
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    a0 = acc_count; p0 = rd_pulses; h0 = res_hs; w0 = wr_count; cyc = 0;
    instr_valid = 1'b1; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd1; wb_en = 1'b1;
    op_ready = 1'b1; res_valid = 1'b1; res_data = 16'h0101;
    while (acc_count - a0 < RMOD + 1 && cyc < 2000) begin @(negedge clk); cyc++; end
    instr_valid = 1'b0;
    while (res_hs - h0 < RMOD + 1 && cyc < 2000) begin @(negedge clk); cyc++; end
    if (cyc >= 2000) timeout("b2b");
    op_ready = 1'b0; res_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_accepts", 32'(acc_count - a0), RMOD + 1);
    check("b2b_reads", 32'(rd_pulses - p0), RMOD + 1);
    check("b2b_writes", 32'(wr_count - w0), RMOD + 1);
    check("b2b_retired_wrap", 32'(retired), (RMOD + 1) % RMOD);
    check("b2b_idle", 32'(instr_ready), 1);
    check("b2b_r1", 32'(mem[1]), 32'h0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Multi-cycle operand-fetch / writeback controller directly upstream of register_file.
- Accepts one decoded instruction (rd/rs1/rs2) and drives register_file read ports. Captures the registered read data and presents both operands to the ALU with a valid/ready handshake.
- Accepts the ALU result and writes it back through register_file port 1. One instruction in flight at a time.

Parameters:
- REG_COUNT, 8, number of architectural registers; must match register_file.
- ADDR_SIZE, $clog2(REG_COUNT), register address width.
- WORD_SIZE, 16, data word width.
- RETIRE_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  decoded instruction available.
- instr_ready  out  1  sequencer idle, can accept.
- rd  in  ADDR_SIZE  destination register.
- rs1  in  ADDR_SIZE  source register A.
- rs2  in  ADDR_SIZE  source register B.
- wb_en  in  1  instruction writes rd.
- rf_r_en1  out  1  to register_file r_en1.
- rf_r_en2  out  1  to register_file r_en2.
- rf_w_en  out  1  to register_file w_en.
- rf_reg1  out  ADDR_SIZE  to register_file reg1 (read rs1 / write rd).
- rf_reg2  out  ADDR_SIZE  to register_file reg2.
- rf_w_data  out  WORD_SIZE  to register_file w_data.
- rf_r_data1  in  WORD_SIZE  from register_file r_data1.
- rf_r_data2  in  WORD_SIZE  from register_file r_data2.
- op_valid  out  1  operands valid to ALU.
- op_ready  in  1  ALU accepts operands.
- op_a  out  WORD_SIZE  operand A.
- op_b  out  WORD_SIZE  operand B.
- res_valid  in  1  ALU result valid.
- res_data  in  WORD_SIZE  ALU result.
- res_ready  out  1  sequencer accepts result.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset:
  - state = IDLE.
  - op_a, op_b, latched rd/rs1/rs2/wb_en, result latch and retired all = 0.
  - All rf_* enables = 0.
- Output decoding: every output is decoded from registered state or latches only. There is no combinational input-to-output path.
- States: IDLE, READ, CAPTURE, ISSUE, WAIT_RES, WRITE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid, latch rd/rs1/rs2/wb_en and go to READ.
- READ:
  - rf_r_en1 = 1, rf_reg1 = rs1; rf_r_en2 = 1, rf_reg2 = rs2.
  - Always go to CAPTURE.
- CAPTURE:
  - register_file data is valid this cycle (1-cycle read latency).
  - op_a <= rf_r_data1.
  - op_b <= (rs2 == 0) ? 0 : rf_r_data2. register_file does not zero port 2 for r0, so the sequencer must.
  - Go to ISSUE.
- ISSUE:
  - op_valid = 1; op_a and op_b are held stable.
  - On op_ready, go to WAIT_RES. Otherwise stay; op_ready may stall indefinitely.
- WAIT_RES:
  - res_ready = 1.
  - On res_valid, latch res_data.
  - If wb_en && rd != 0, go to WRITE. Otherwise increment retired and go to IDLE.
- WRITE:
  - rf_w_en = 1, rf_r_en1 = 0 (port-1 read has priority in register_file, so it must be low), rf_reg1 = rd, rf_w_data = latched result.
  - Increment retired and go to IDLE.
- Latency:
  - Instruction accept edge to op_valid high = 3 cycles.
  - res_valid edge to write-enable cycle = 1 cycle.
- Idle behaviour: outside READ and WRITE, all rf enables are 0 and rf_reg1/rf_reg2 hold their last values.
- Simultaneous events: none possible. instr_ready is high only in IDLE and res_ready only in WAIT_RES, so a new instruction is never accepted while a result is pending.
- retired: wraps modulo 2^RETIRE_W. It increments exactly once per completed instruction, including writes to r0 and instructions with wb_en = 0.
- Reset mid-operation: the instruction is abandoned, no write is issued in the following cycle, and retired is cleared.
- Handshake inputs (op_ready, res_valid): ignored outside ISSUE and WAIT_RES respectively.

Test Plan:
- Reset, then preload r3 = 0x1234 and r5 = 0x00FF. Issue rs1 = 3, rs2 = 5, rd = 2, wb_en = 1.
  - -> op_valid 3 cycles after accept, with op_a = 0x1234, op_b = 0x00FF.
  - ALU returns 0x1333 -> r2 = 0x1333 and retired = 1.
- Issue rs2 = 0 while the register_file r0 cell holds garbage via port-2 path -> op_b = 0x0000.
- Issue rd = 0, wb_en = 1, result 0xBEEF -> rf_w_en never asserted, r0 reads 0, retired increments.
- Hold op_ready = 0 for 10 cycles in ISSUE -> op_valid stays 1 and op_a/op_b stay constant. Release -> completes normally.
- Assert reset during WAIT_RES -> state IDLE next cycle, no rf_w_en pulse, retired = 0, instr_ready = 1.
- Run 65537 back-to-back instructions with RETIRE_W = 16 -> retired = 1 (wrap). instr_valid held high is accepted only in IDLE.
